// File: rtl/function_total_inverse_if.sv
// ---------------------------------------------------------------------------
// function_total_inverse_if
// Request/result bundle for the area-to-width inverter.
//   in_valid / in_ready / area        : request side (area = total area to invert)
//   out_valid / out_ready             : result handshake
//   width / exact / saturated / residual : registered result fields
// master : the requester/consumer (drives requests, takes results)
// slave  : the inverter itself
// ---------------------------------------------------------------------------
interface function_total_inverse_if;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] area;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  width;
   logic        exact;
   logic        saturated;
   logic [16:0] residual;

   modport master (
      output in_valid, area, out_ready,
      input  in_ready, out_valid, width, exact, saturated, residual
   );

   modport slave (
      input  in_valid, area, out_ready,
      output in_ready, out_valid, width, exact, saturated, residual
   );
endinterface

// File: rtl/function_total_inverse.sv
// ---------------------------------------------------------------------------
// function_total_inverse
// Recovers the largest 8-bit width w whose total area
//    total(w) = w*w + floor(CIRC_COEF*w*w/256)
// does not exceed the requested area. The answer is built MSB first by
// successive approximation, one trial bit per clock, so a result appears
// eight cycles after the request is accepted.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : function_total_inverse_if.slave
//          (in_valid/in_ready/area request, out_valid/out_ready handshake,
//           width/exact/saturated/residual result fields)
// ---------------------------------------------------------------------------
module function_total_inverse #(
   parameter int CIRC_COEF = 201
) (
   input logic                     CLK,
   input logic                     RST,
   function_total_inverse_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [23:0] COEF24 = 24'(CIRC_COEF);

   // Full-precision total: the square is kept at 16 bits and the circle
   // product at 24 bits so nothing is lost before the divide by 256.
   function automatic logic [16:0] totalOf(input logic [7:0] w);
      logic [15:0] sq;
      logic [23:0] prod;
      sq   = {8'd0, w} * {8'd0, w};
      prod = COEF24 * {8'd0, sq};
      return {1'b0, sq} + {1'b0, prod[23:8]};
   endfunction

   state_t      r_state;
   state_t      w_nextState;
   logic [16:0] r_area;
   logic [7:0]  r_acc;
   logic [2:0]  r_idx;
   logic [7:0]  r_width;
   logic        r_exact;
   logic        r_saturated;
   logic [16:0] r_residual;
   logic        r_outValid;

   logic        w_load;
   logic        w_step;
   logic        w_handoff;
   logic [7:0]  w_trial;
   logic [16:0] w_trialTotal;
   logic [7:0]  w_nextAcc;
   logic [16:0] w_finalTotal;
   logic [16:0] w_residual;

   // One candidate per cycle: set the current bit and keep it only if the
   // resulting total still fits under the latched area. Because total(w) is
   // monotonic, this lands on the largest fitting width.
   always_comb begin
      w_trial      = r_acc | (8'd1 << r_idx);
      w_trialTotal = totalOf(w_trial);
      w_nextAcc    = (w_trialTotal <= r_area) ? w_trial : r_acc;
      w_finalTotal = totalOf(w_nextAcc);
      w_residual   = r_area - w_finalTotal;
   end

   // Next-state and control strobes. Requests are only taken in IDLE and
   // results only leave from DONE, so a request can never be accepted on the
   // same edge that a result is handed off.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_handoff   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_load      = 1'b1;
               w_nextState = SEARCH;
            end
         end
         SEARCH: begin
            w_step = 1'b1;
            if (r_idx == 3'd0) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (r_outValid && bus.out_ready) begin
               w_handoff   = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Search datapath and result registers. The result fields are loaded on
   // the bit-0 step and then left alone, so they stay stable while waiting
   // for the consumer and keep their values after the handoff.
   // Saturation needs no separate compare: a search that ends at 255 with
   // area left over can only mean the area exceeds total(255).
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_area      <= 17'd0;
         r_acc       <= 8'd0;
         r_idx       <= 3'd0;
         r_width     <= 8'd0;
         r_exact     <= 1'b0;
         r_saturated <= 1'b0;
         r_residual  <= 17'd0;
         r_outValid  <= 1'b0;
      end else begin
         if (w_load) begin
            r_area <= bus.area;
            r_acc  <= 8'd0;
            r_idx  <= 3'd7;
         end
         if (w_step) begin
            r_acc <= w_nextAcc;
            r_idx <= r_idx - 3'd1;
            if (r_idx == 3'd0) begin
               r_width     <= w_nextAcc;
               r_residual  <= w_residual;
               r_exact     <= (w_residual == 17'd0);
               r_saturated <= (w_nextAcc == 8'hFF) && (w_residual != 17'd0);
               r_outValid  <= 1'b1;
            end
         end
         if (w_handoff) begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_outValid;
   assign bus.width     = r_width;
   assign bus.exact     = r_exact;
   assign bus.saturated = r_saturated;
   assign bus.residual  = r_residual;

endmodule

// File: tb/tb_function_total_inverse.sv
// ---------------------------------------------------------------------------
// tb_function_total_inverse
// Drives area requests into function_total_inverse and checks each result
// against a reference that finds the width by plain exhaustive search over
// all 256 candidates.
// ---------------------------------------------------------------------------
module tb_function_total_inverse;

   localparam int CIRC = 201;

   logic CLK;
   logic RST;
   int   nTests;
   int   nFailed;

   function_total_inverse_if bus ();

   function_total_inverse #(.CIRC_COEF(CIRC)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Safety net against a hung run.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference area model and inverse, straight from the arithmetic.
   function automatic int modelTotal(input int w);
      return w * w + (CIRC * w * w) / 256;
   endfunction

   function automatic int modelWidth(input int a);
      int best;
      best = 0;
      for (int c = 0; c < 256; c++) begin
         if (modelTotal(c) <= a) best = c;
      end
      return best;
   endfunction

   task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nTests++;
      assert (observed === expected)
      else begin
         nFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Full result check against the reference model.
   task automatic checkOutput(input int a);
      int w;
      int r;
      w = modelWidth(a);
      r = a - modelTotal(w);
      checkField("width", 32'(bus.width), 32'(w));
      checkField("residual", 32'(bus.residual), 32'(r));
      checkField("exact", 32'(bus.exact), 32'(r == 0));
      checkField("saturated", 32'(bus.saturated), 32'(a > modelTotal(255)));
   endtask

   task automatic waitReady();
      for (int i = 0; i < 20; i++) begin
         if (bus.in_ready) break;
         @(negedge CLK);
      end
      if (!bus.in_ready) checkField("in_ready timeout", 32'(bus.in_ready), 32'd1);
   endtask

   // Issues one request and waits for its result, checking the latency.
   task automatic applyStimulus(input int a);
      int lat;
      waitReady();
      bus.in_valid = 1'b1;
      bus.area     = 17'(a);
      @(posedge CLK);
      @(negedge CLK);
      bus.in_valid = 1'b0;
      bus.area     = 17'($urandom);
      lat = -1;
      if (bus.out_valid) lat = 0;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (bus.out_valid) lat = i;
      end
      if (lat < 0) checkField("out_valid timeout", 32'(bus.out_valid), 32'd1);
      checkField("latency", 32'(lat), 32'd8);
   endtask

   // Takes the pending result and checks the return to IDLE.
   task automatic takeResult();
      checkField("in_ready in DONE", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      bus.out_ready = 1'b0;
      checkField("out_valid after take", 32'(bus.out_valid), 32'd0);
      checkField("in_ready after take", 32'(bus.in_ready), 32'd1);
   endtask

   // Directed points with hand-worked answers.
   int dArea [8] = '{0, 7, 17851, 17850, 15, 116079, 131071, 457};
   int dWidth[8] = '{0, 2, 100, 99, 2, 255, 255, 16};
   int dExact[8] = '{1, 1, 1, 0, 0, 1, 0, 1};
   int dSat  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
   int dRes  [8] = '{0, 0, 0, 354, 8, 0, 14992, 0};

   initial begin
      int a;
      int t;
      logic [7:0] expW;
      logic [16:0] expR;
      nTests        = 0;
      nFailed       = 0;
      RST           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.area      = 17'd0;

      // Reset state.
      #23;
      checkField("reset in_ready", 32'(bus.in_ready), 32'd1);
      checkField("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkField("reset width", 32'(bus.width), 32'd0);
      checkField("reset exact", 32'(bus.exact), 32'd0);
      checkField("reset saturated", 32'(bus.saturated), 32'd0);
      checkField("reset residual", 32'(bus.residual), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Directed points.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(dArea[i]);
         checkField("directed width", 32'(bus.width), 32'(dWidth[i]));
         checkField("directed exact", 32'(bus.exact), 32'(dExact[i]));
         checkField("directed saturated", 32'(bus.saturated), 32'(dSat[i]));
         checkField("directed residual", 32'(bus.residual), 32'(dRes[i]));
         checkOutput(dArea[i]);
         takeResult();
      end

      // Backpressure: result must hold and new requests must be ignored.
      a = 50000;
      applyStimulus(a);
      expW = 8'(modelWidth(a));
      expR = 17'(a - modelTotal(modelWidth(a)));
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = i[0];
         bus.area     = 17'($urandom);
         @(posedge CLK);
         @(negedge CLK);
         checkField("hold out_valid", 32'(bus.out_valid), 32'd1);
         checkField("hold in_ready", 32'(bus.in_ready), 32'd0);
         checkField("hold width", 32'(bus.width), 32'(expW));
         checkField("hold residual", 32'(bus.residual), 32'(expR));
      end
      bus.in_valid = 1'b0;
      takeResult();
      checkField("width kept after take", 32'(bus.width), 32'(expW));

      // Reset in the middle of a search.
      waitReady();
      bus.in_valid = 1'b1;
      bus.area     = 17'd17851;
      @(posedge CLK);
      @(negedge CLK);
      bus.in_valid = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checkField("midreset out_valid", 32'(bus.out_valid), 32'd0);
      checkField("midreset in_ready", 32'(bus.in_ready), 32'd1);
      checkField("midreset width", 32'(bus.width), 32'd0);
      checkField("midreset residual", 32'(bus.residual), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         checkField("no stale out_valid", 32'(bus.out_valid), 32'd0);
      end
      applyStimulus(dArea[7]);
      checkField("post-reset width", 32'(bus.width), 32'(dWidth[7]));
      checkField("post-reset exact", 32'(bus.exact), 32'(dExact[7]));
      checkOutput(dArea[7]);
      takeResult();

      // Sweep every exact point and the point just above it.
      for (int w = 0; w < 256; w++) begin
         t = modelTotal(w);
         applyStimulus(t);
         checkField("sweep width", 32'(bus.width), 32'(w));
         checkOutput(t);
         takeResult();
         if (w == 255 || t + 1 < modelTotal(w + 1)) begin
            applyStimulus(t + 1);
            checkField("sweep+1 width", 32'(bus.width), 32'(w));
            checkOutput(t + 1);
            takeResult();
         end
      end

      // Random areas across the whole input range.
      for (int i = 0; i < 40; i++) begin
         a = int'($urandom_range(131071, 0));
         applyStimulus(a);
         checkOutput(a);
         takeResult();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
      $finish;
   end

endmodule

// File: doc/function_total_inverse.md
Name: function_total_inverse

Overview:
- Inverse of the area calculator. Takes a 17-bit total area and returns the largest 8-bit width w with square(w)+circle(w) <= area.
- Area model: square(w) = w*w; circle(w) = floor(CIRC_COEF*w*w/256).
- Solved by 8-step successive approximation, MSB first, one trial per clock.
- Sits downstream of the area path and recovers width for consistency checking; valid/ready handshakes on both sides.

Parameters:
- CIRC_COEF, 201: circle coefficient, in 1/256 units (201/256 ~ pi/4). total(w) must stay monotonic non-decreasing and total(255) must be < 2^17. Legal range: 0..255.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous active-low reset
- in_valid  input  1  area request valid
- in_ready  output  1  block can accept a request
- area  input  17  unsigned area to invert; sampled on acceptance
- out_valid  output  1  result valid; held until taken
- out_ready  input  1  consumer takes the result
- width  output  8  largest w with total(w) <= area
- exact  output  1  total(width) == area
- saturated  output  1  area > total(255); width forced to 255
- residual  output  17  area - total(width), unsigned

Behaviour:
- Reset (RST low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0.
  - width, exact, saturated, residual = 0.
  - Internal area register and trial register = 0.
- total(w): {1'b0,w*w} + floor(CIRC_COEF*w*w/256).
  - Compute w*w at 16 bits and the product at 24 bits before the divide by 256; no truncation before the shift.
  - Result is 17 bits; it cannot overflow.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: latch area, acc=0, bit index=7, go to SEARCH.
- SEARCH, edges E1..E8, one bit per edge, bit 7 down to bit 0:
  - trial = acc | (1<<idx).
  - If total(trial) <= area_reg, acc = trial; else acc is unchanged.
  - After the bit-0 step (E8), go to DONE.
  - On the same edge, register width=final acc, exact, saturated, residual, and set out_valid=1.
- Latency: out_valid is high after edge E8, 8 cycles after acceptance. Results are registered; outputs are stable while out_valid=1.
- DONE:
  - in_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE. in_ready rises the following cycle, so results are never accepted and requested on the same edge.
  - Output fields keep their last values after handoff.
- in_ready=0 in SEARCH and DONE. in_valid is ignored there and the area input may change freely.
- saturated=1 iff area_reg > total(255).
  - width=255 in that case (falls out of the search naturally).
  - residual = area_reg - total(255).
  - exact=0.
- area=0 -> width=0, exact=1, residual=0.
- Reset mid-SEARCH or mid-DONE: immediate return to reset state. Any pending result is discarded; no out_valid pulse follows.
- out_ready high while out_valid=0 has no effect.

Test Plan:
- Exact points, CIRC_COEF=201:
  - area 0 -> width 0, exact 1.
  - area 7 -> width 2, exact 1 (4+3).
  - area 17851 -> width 100, exact 1, residual 0.
  - Check out_valid rises exactly 8 cycles after acceptance.
- Between points: area 17850 -> width 99, exact 0, residual 354 (total(99)=17496).
  - area 15 -> width 2, residual 8 (total(3)=16).
- Saturation:
  - area 116079 -> width 255, exact 1, saturated 0.
  - area 131071 -> width 255, saturated 1, exact 0, residual 14992.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - Outputs must stay stable, in_ready must stay 0, and in_valid pulses must be ignored.
  - Release out_ready: out_valid drops and in_ready=1 on the next cycle.
- Reset mid-operation: assert RST at E4 of a search for area 17851.
  - All outputs go to 0 immediately with no out_valid.
  - A new request for area 457 -> width 16, exact 1.
- Exhaustive sweep: for w=0..255, apply total(w) and total(w)+1, checked against a behavioural model.
  - Expect width=w, exact 1 / exact 0, residual 0 / 1 (where total(w)+1 < total(w+1)).
